// File: rtl/arbitrated_stream_mux.sv
// N:1 stream selector with valid/ready handshakes, fixed-priority or round-robin
// arbitration, and a single registered output stage tagged with the winning channel.
module arbitrated_stream_mux #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2,
    parameter int MODE      = 0
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [CHANNELS-1:0]       i_in_valid,
    output logic [CHANNELS-1:0]       o_in_ready,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [WIDTH-1:0]          o_out_data,
    output logic [SEL_WIDTH-1:0]      o_out_channel
);

    localparam logic [SEL_WIDTH:0]   LP_CH   = (SEL_WIDTH+1)'(CHANNELS);
    localparam logic [SEL_WIDTH-1:0] LP_LAST = SEL_WIDTH'(CHANNELS - 1);

    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;
    logic [SEL_WIDTH-1:0]  r_out_channel;
    logic [SEL_WIDTH-1:0]  r_rr_ptr;

    logic                  w_can_accept;
    logic                  w_found;
    logic                  w_transfer;
    logic [SEL_WIDTH-1:0]  w_base;
    logic [SEL_WIDTH-1:0]  w_grant_idx;
    logic [CHANNELS-1:0]   w_grant;
    logic [WIDTH-1:0]      w_sel_data;

    assign w_can_accept = ~r_out_valid | i_out_ready;
    assign w_base       = (MODE == 1) ? r_rr_ptr : {SEL_WIDTH{1'b0}};
    assign w_transfer   = w_found & w_can_accept & ~i_reset;

    // Search valid channels starting at w_base, wrapping modulo CHANNELS; first hit wins.
    always_comb begin
        logic [SEL_WIDTH:0]   w_sum;
        logic [SEL_WIDTH-1:0] w_idx;
        logic                 w_hit;
        w_grant     = {CHANNELS{1'b0}};
        w_grant_idx = {SEL_WIDTH{1'b0}};
        w_found     = 1'b0;
        w_sum       = {(SEL_WIDTH+1){1'b0}};
        w_idx       = {SEL_WIDTH{1'b0}};
        w_hit       = 1'b0;
        for (int off = 0; off < CHANNELS; off++) begin
            w_sum          = {1'b0, w_base} + (SEL_WIDTH+1)'(off);
            w_sum          = (w_sum >= LP_CH) ? (w_sum - LP_CH) : w_sum;
            w_idx          = w_sum[SEL_WIDTH-1:0];
            w_hit          = ~w_found & i_in_valid[w_idx];
            w_grant[w_idx] = w_grant[w_idx] | w_hit;
            w_grant_idx    = w_hit ? w_idx : w_grant_idx;
            w_found        = w_found | w_hit;
        end
    end

    // One-hot AND-OR select of the granted channel's word.
    always_comb begin
        w_sel_data = {WIDTH{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            w_sel_data = w_sel_data | ({WIDTH{w_grant[k]}} & i_in_data[k*WIDTH +: WIDTH]);
        end
    end

    assign o_in_ready = w_grant & {CHANNELS{w_can_accept & ~i_reset}};

    // Output register and round-robin pointer; reset overrides any concurrent transfer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= {WIDTH{1'b0}};
            r_out_channel <= {SEL_WIDTH{1'b0}};
            r_rr_ptr      <= {SEL_WIDTH{1'b0}};
        end else if (w_transfer) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_sel_data;
            r_out_channel <= w_grant_idx;
            if (MODE == 1) begin
                r_rr_ptr <= (w_grant_idx == LP_LAST) ? {SEL_WIDTH{1'b0}}
                                                     : w_grant_idx + SEL_WIDTH'(1);
            end else begin
                r_rr_ptr <= {SEL_WIDTH{1'b0}};
            end
        end else if (i_out_ready) begin
            r_out_valid   <= 1'b0;
        end else begin
            r_out_valid   <= r_out_valid;
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_channel = r_out_channel;

endmodule
